// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32IM 5-stage hazard control (forwarding, load-use stall, branch flush, divide sequencing)
// Ports: rs*/rd* register addresses from ID/EX/MEM/WB; regwrite_m/w, load_e, pc_src_e, div_e decode flags;
// forward_a_e/forward_b_e operand mux selects; stall_f/d/e, flush_d/e/m pipeline controls;
// div_busy/div_done divider FSM status (registered).
module hazard_ctrl #(
  parameter int DIV_LATENCY = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              load_e,
  input  logic              pc_src_e,
  input  logic              div_e,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              div_busy,
  output logic              div_done
);
  localparam int CW = $clog2(DIV_LATENCY);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic lwstall, div_stall, hit_m_a, hit_w_a, hit_m_b, hit_w_b;
  always_comb begin
    hit_m_a = regwrite_m && rd_m != '0 && rd_m == rs1_e;
    hit_w_a = regwrite_w && rd_w != '0 && rd_w == rs1_e;
    hit_m_b = regwrite_m && rd_m != '0 && rd_m == rs2_e;
    hit_w_b = regwrite_w && rd_w != '0 && rd_w == rs2_e;
    forward_a_e = hit_m_a ? 2'b10 : hit_w_a ? 2'b01 : 2'b00;
    forward_b_e = hit_m_b ? 2'b10 : hit_w_b ? 2'b01 : 2'b00;
    lwstall = load_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
    div_stall = (state == IDLE && div_e) || state == BUSY;
    stall_f = lwstall || div_stall;
    stall_d = lwstall || div_stall;
    stall_e = div_stall;
    flush_m = div_stall;
    flush_e = (lwstall || pc_src_e) && !div_stall;
    flush_d = pc_src_e && !div_stall;
  end
  // cnt is loaded with DIV_LATENCY-2 so BUSY plus the entry cycle span exactly DIV_LATENCY stall cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      div_busy <= 1'b0;
      div_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_e) begin
          state <= BUSY;
          cnt <= CW'(DIV_LATENCY - 2);
          div_busy <= 1'b1;
        end
        BUSY: if (cnt == '0) begin
          state <= DONE;
          div_busy <= 1'b0;
          div_done <= 1'b1;
        end else cnt <= cnt - 1'b1;
        DONE: begin
          state <= IDLE;
          div_done <= 1'b0;
        end
        default: begin
          state <= IDLE;
          div_busy <= 1'b0;
          div_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a phase-count divide model
module tb_hazard_ctrl;
  localparam int L = 32;
  localparam int L2 = 2;
  logic clk = 0, rst_n = 0;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic regwrite_m, regwrite_w, load_e, pc_src_e, div_e;
  logic [1:0] forward_a_e, forward_b_e, fa2, fb2;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, div_busy, div_done;
  logic sf2, sd2, se2, fd2, fe2, fm2, busy2, done2;
  int total = 0, bad = 0;
  int ph = -1, ph2 = -1;
  bit live = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.DIV_LATENCY(L), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .div_e(div_e), .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .div_busy(div_busy), .div_done(div_done));
  hazard_ctrl #(.DIV_LATENCY(L2), .REG_AW(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .load_e(load_e), .pc_src_e(pc_src_e), .div_e(div_e), .forward_a_e(fa2),
    .forward_b_e(fb2), .stall_f(sf2), .stall_d(sd2), .stall_e(se2),
    .flush_d(fd2), .flush_e(fe2), .flush_m(fm2), .div_busy(busy2), .div_done(done2));
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // phase of the divide in the current cycle: -1 idle, 0 = entry cycle, L = done cycle
  function automatic int cur(int p, logic de);
    return p < 0 ? (de ? 0 : -1) : p;
  endfunction
  function automatic int nxt(int c, int lat);
    return (c < 0 || c == lat) ? -1 : c + 1;
  endfunction
  function automatic int fwd(logic [4:0] rs);
    if (regwrite_m && rd_m != 0 && rd_m == rs) return 2;
    if (regwrite_w && rd_w != 0 && rd_w == rs) return 1;
    return 0;
  endfunction
  always @(posedge clk) begin
    ph <= rst_n ? nxt(cur(ph, div_e), L) : -1;
    ph2 <= rst_n ? nxt(cur(ph2, div_e), L2) : -1;
  end
  always @(negedge clk) if (live) begin
    int c, c2;
    bit lw, ds, ds2;
    c = cur(ph, div_e);
    c2 = cur(ph2, div_e);
    lw = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    ds = c >= 0 && c < L;
    ds2 = c2 >= 0 && c2 < L2;
    chk("m_fwd_a", forward_a_e, fwd(rs1_e));
    chk("m_fwd_b", forward_b_e, fwd(rs2_e));
    chk("m_stall_f", stall_f, int'(lw || ds));
    chk("m_stall_d", stall_d, int'(lw || ds));
    chk("m_stall_e", stall_e, int'(ds));
    chk("m_flush_m", flush_m, int'(ds));
    chk("m_flush_e", flush_e, int'((lw || pc_src_e) && !ds));
    chk("m_flush_d", flush_d, int'(pc_src_e && !ds));
    chk("m_busy", div_busy, int'(c >= 1 && c < L));
    chk("m_done", div_done, int'(c == L));
    chk("m2_stall_e", se2, int'(ds2));
    chk("m2_flush_e", fe2, int'((lw || pc_src_e) && !ds2));
    chk("m2_busy", busy2, int'(c2 >= 1 && c2 < L2));
    chk("m2_done", done2, int'(c2 == L2));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {regwrite_m, regwrite_w, load_e, pc_src_e, div_e} = '0;
  endtask
  initial begin
    int ns, nb, nd, nz, d1, d2, late;
    clr();
    step();
    step();
    rst_n = 1;
    live = 1;
    @(negedge clk);
    chk("rst_busy", div_busy, 0);
    chk("rst_done", div_done, 0);
    chk("rst_stall_e", stall_e, 0);
    step();
    rs1_e = 5; rd_m = 5; rd_w = 5; regwrite_m = 1; regwrite_w = 1;
    @(negedge clk);
    chk("fwd_mem_prio", forward_a_e, 2);
    step();
    regwrite_m = 0;
    @(negedge clk);
    chk("fwd_wb", forward_a_e, 1);
    step();
    rd_m = 0; rd_w = 0; rs1_e = 0; regwrite_m = 1;
    @(negedge clk);
    chk("fwd_x0", forward_a_e, 0);
    step();
    clr();
    load_e = 1; rd_e = 7; rs2_d = 7;
    @(negedge clk);
    chk("lu_stall_f", stall_f, 1);
    chk("lu_stall_d", stall_d, 1);
    chk("lu_flush_e", flush_e, 1);
    chk("lu_stall_e", stall_e, 0);
    step();
    rd_e = 0;
    @(negedge clk);
    chk("lu_x0", {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}, 0);
    step();
    clr();
    pc_src_e = 1;
    @(negedge clk);
    chk("br_flush_d", flush_d, 1);
    chk("br_flush_e", flush_e, 1);
    chk("br_stalls", {stall_f, stall_d, stall_e}, 0);
    step();
    clr();
    ns = 0; nb = 0; nd = 0; d1 = -1;
    for (int k = 0; k < 34; k++) begin
      div_e = k <= 32;
      @(negedge clk);
      ns += int'(stall_e && flush_m);
      nb += int'(div_busy);
      if (div_done) begin nd++; d1 = k; end
      step();
    end
    chk("div_stall_cycles", ns, 32);
    chk("div_busy_cycles", nb, 31);
    chk("div_done_count", nd, 1);
    chk("div_done_cycle", d1, 32);
    nz = 0; nd = 0; d1 = -1; d2 = -1;
    for (int k = 0; k < 67; k++) begin
      div_e = k <= 65;
      @(negedge clk);
      if (k <= 65 && !stall_e) nz++;
      if (div_done) begin
        nd++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
      step();
    end
    chk("b2b_done_count", nd, 2);
    chk("b2b_done_first", d1, 32);
    chk("b2b_done_second", d2, 65);
    chk("b2b_stall_gaps", nz, 2);
    late = 0;
    for (int k = 0; k < 41; k++) begin
      div_e = k <= 10;
      rst_n = k != 10;
      @(negedge clk);
      if (k >= 11) late += int'(div_busy) + int'(stall_e) + int'(div_done);
      step();
    end
    rst_n = 1;
    chk("rst_mid_div", late, 0);
    for (int k = 0; k < 1500; k++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
      regwrite_m = 1'($urandom); regwrite_w = 1'($urandom); load_e = 1'($urandom);
      div_e = $urandom_range(0, 9) == 0;
      pc_src_e = !div_e && $urandom_range(0, 3) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      step();
    end
    rst_n = 1;
    clr();
    step();
    live = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32IM 5-stage core. It drives the 2-bit select inputs of the two execute-stage operand forwarding multiplexers (SrcA/SrcB). It also generates the per-stage stall and flush controls for load-use hazards and taken branches/jumps. It sequences the multi-cycle divide in EX with a counter FSM, freezing the front of the pipeline until the divider result is ready.

## Interface
- DIV_LATENCY, 32, total EX-occupancy cycles of a DIV/DIVU/REM/REMU; legal range 2..64
- REG_AW, 5, register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- rs1_d, rs2_d  in  REG_AW  source registers of instruction in ID
- rs1_e, rs2_e  in  REG_AW  source registers of instruction in EX
- rd_e, rd_m, rd_w  in  REG_AW  destination registers in EX/MEM/WB
- regwrite_m, regwrite_w  in  1  MEM/WB instruction writes the register file
- load_e  in  1  instruction in EX is a load
- pc_src_e  in  1  taken branch or jump resolved in EX
- div_e  in  1  instruction in EX is a divide/remainder
- forward_a_e, forward_b_e  out  2  mux select: 00 register file, 01 WB result, 10 MEM ALU result
- stall_f, stall_d, stall_e  out  1  hold PC, IF/ID, ID/EX registers
- flush_d, flush_e, flush_m  out  1  clear IF/ID, ID/EX, EX/MEM registers to bubbles
- div_busy  out  1  divider FSM in BUSY
- div_done  out  1  divide result valid this cycle (FSM in DONE)

## Operation
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Forwarding is combinational and evaluated per operand (shown for A, same for B with rs2_e):
  - 10 if regwrite_m & rd_m!=0 & rd_m==rs1_e.
  - else 01 if regwrite_w & rd_w!=0 & rd_w==rs1_e.
  - else 00.
  - MEM has priority over WB. x0 never forwards.
- Load-use: lwstall = load_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- Divide FSM, states IDLE, BUSY, DONE; down-counter cnt of width $clog2(DIV_LATENCY):
  - IDLE: if div_e, div_stall=1, next BUSY, cnt<=DIV_LATENCY-2.
  - BUSY: div_stall=1. If cnt==0, next DONE; else cnt<=cnt-1.
  - DONE: div_stall=0, div_done=1. Always next IDLE. div_e is ignored in DONE because the same divide is still in EX.
- div_stall is internal: (IDLE & div_e) | BUSY.
- Outputs:
  - stall_f = stall_d = lwstall | div_stall
  - stall_e = div_stall
  - flush_m = div_stall
  - flush_e = (lwstall | pc_src_e) & ~div_stall
  - flush_d = pc_src_e & ~div_stall
- pc_src_e and div_e are mutually exclusive by decode; no priority is defined between them.
- Reset (rst_n=0 at an edge): state<=IDLE, cnt<=0. Afterwards div_busy=0 and div_done=0. All stall/flush outputs then depend only on lwstall and pc_src_e.
- Reset mid-divide: the divide is abandoned and div_stall drops in the cycle after the reset edge.

## Timing
- Forwarding selects, lwstall, stalls and flushes are combinational, with zero-cycle latency from their inputs.
- Divide sequence, with cycle 0 = first cycle div_e=1 in IDLE:
  - div_stall=1 in cycles 0..DIV_LATENCY-1, exactly DIV_LATENCY cycles.
  - div_busy=1 in cycles 1..DIV_LATENCY-1.
  - div_done=1 in cycle DIV_LATENCY only; the divide leaves EX at the end of that cycle.
  - IDLE again in cycle DIV_LATENCY+1.
- Back-to-back divides: the second divide enters EX in cycle DIV_LATENCY+1, sees IDLE with div_e=1, and restarts with no gap cycle.
- DIV_LATENCY=2: BUSY lasts exactly one cycle with cnt=0.
- Load-use during a divide: stall_d stays 1 and flush_e stays 0, so the divide is not killed. lwstall is re-evaluated after DONE.

## Test plan
- Forward priority: rs1_e=5, rd_m=5, rd_w=5, regwrite_m=1, regwrite_w=1 -> forward_a_e=10. Clear regwrite_m -> 01. Set rd_m=rd_w=0 with rs1_e=0 -> 00.
- Load-use: load_e=1, rd_e=7, rs2_d=7 -> stall_f=1, stall_d=1, flush_e=1, stall_e=0. With rd_e=0 -> all 0.
- Branch flush: pc_src_e=1, no divide -> flush_d=1, flush_e=1, all stalls 0.
- Divide, DIV_LATENCY=32: div_e held 1 from cycle 0 -> stall_e=1 and flush_m=1 for cycles 0..31; div_busy=1 for cycles 1..31; div_done=1 only in cycle 32; back in IDLE at cycle 33.
- Back-to-back divides: div_e=1 continuously for two instructions -> div_done pulses at cycles 32 and 65, and stall_e=0 only in those two cycles.
- Reset mid-divide: rst_n=0 sampled at cycle 10 -> from cycle 11 div_busy=0, stall_e=0, and div_done never pulses.
